pwm_fade_gen: RTL
=================

Name: pwm_fade_gen

Overview:
- Duty-cycle sequencer directly upstream of the 8-bit PWM stage; drives its `compare` input.
- Produces a periodic "breathing" envelope in five phases: ramp up from a minimum level, hold at maximum, ramp down, hold at minimum, repeat.
- Updates `compare` only at PWM period boundaries, so the downstream stage never sees a mid-period duty change.

Parameters:
- CTR_LEN, 8: width of `compare`; the PWM period is 2^CTR_LEN clocks, and this must match the downstream PWM.
- DWELL_LEN, 16: width of the dwell/hold period counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- enable  in  1  start/continue fading; sampled only in IDLE and at HOLD_LO exit
- level_min  in  CTR_LEN  lowest duty level
- level_max  in  CTR_LEN  highest duty level
- step  in  CTR_LEN  duty increment per step; 0 treated as 1
- periods_per_step  in  DWELL_LEN  each ramp level lasts periods_per_step+1 PWM periods
- hold_periods  in  DWELL_LEN  each extreme lasts hold_periods+1 PWM periods
- compare  out  CTR_LEN  duty value to the PWM stage (registered)
- period_tick  out  1  high in the last clock of each PWM period (registered)
- state  out  3  current phase: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4
- cycle_done  out  1  one-clock pulse at HOLD_LO exit

Behaviour:
- Reset values: compare=0, state=IDLE, cycle_done=0, period_tick=0; internal period counter=0, dwell=0.
- Period counter: CTR_LEN bits, free-running from reset, wraps all-ones -> 0.
  - period_tick=1 exactly when the counter equals all-ones. Equivalently, it asserts in clock 2^CTR_LEN-1 after reset release, then every 2^CTR_LEN clocks.
  - The downstream PWM is reset by the same rst, so periods align.
- Timing of state changes: state, compare and dwell change only in a period_tick cycle. The new compare is therefore valid from the first clock of the next period.
- Config latching: level_min, level_max, step and periods_per_step are latched into shadow registers at every cycle start (IDLE->UP and HOLD_LO->UP). hold_periods is latched with them. All arithmetic uses the latched values.
- Ramp arithmetic: computed at CTR_LEN+1 bits; no wrap.
  - Up-step: if compare+step >= max, set compare=max and go to HOLD_HI (dwell=0); else compare += step.
  - Down-step: if compare <= min+step, set compare=min and go to HOLD_LO (dwell=0); else compare -= step.
- Step event (UP/DOWN): at a tick where dwell==periods_per_step, apply the step and set dwell=0; otherwise dwell++.
- IDLE: compare=0. At a tick with enable=1: latch config, compare=min, dwell=0, go to UP.
- UP: apply up-steps on step events.
- HOLD_HI: at a tick with dwell==hold_periods, apply one down-step immediately and set dwell=0. If that step reaches min, go to HOLD_LO; otherwise go to DOWN. At all other ticks, dwell++.
- DOWN: apply down-steps on step events.
- HOLD_LO: at a tick with dwell==hold_periods, pulse cycle_done for that clock, then:
  - enable=1: latch config, apply one up-step from min, go to UP, dwell=0. If that step reaches max, go to HOLD_HI.
  - enable=0: compare=0, go to IDLE.
- Graceful stop: deasserting enable mid-cycle does not abort. The cycle completes through HOLD_LO, then enters IDLE.
- Degenerate config:
  - latched min>=max: the first up-step clamps to max, and the first down-step clamps to min. The sequence stays defined and never wraps.
  - Config input changes mid-cycle are ignored until the next latch.
- rst mid-operation: all state returns to reset values on the next clock edge, regardless of phase.

Test Plan:
- CTR_LEN=4. Release rst -> period_tick first high at clock 15, then every 16 clocks. compare=0 and state=IDLE while enable=0.
- CTR_LEN=4, min=2, max=10, step=3, pps=0, hold=1, enable=1 held -> per-period compare sequence 2,5,8,10,10,7,4,2,2,5,8... cycle_done pulses once, at the tick where 2,2 becomes 5.
- Same config, enable dropped during the first UP -> sequence completes 2,5,8,10,10,7,4,2,2, then compare=0 and state=IDLE. cycle_done pulses once.
- pps=2, step=0, min=0, max=3, hold=0 -> each level 0,1,2 lasts 3 periods; 3 lasts 1 period; then 2,1 last 3 periods each; then 0. Verifies step=0 treated as 1.
- min=200, max=100, CTR_LEN=8 -> compare 200, then 100, then 200 (clamped), with no wrap. level_max changed to 250 mid-cycle -> no effect until the next latch.
- rst asserted during HOLD_HI -> next clock: compare=0, state=IDLE, period_tick=0, and the period counter restarts from 0.

Source files
------------

// File: rtl/pwm_fade_gen.sv
// ---------------------------------------------------------------------------
// pwm_fade_gen
//
// Breathing-envelope duty sequencer that sits directly in front of an
// 8-bit-style PWM stage and drives its compare input. The envelope runs
// through five phases: ramp up from the minimum level, hold at the maximum,
// ramp down, hold at the minimum, then repeat. The compare value only ever
// changes at a PWM period boundary, so the PWM stage never sees a duty
// change in the middle of a period.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   enable           start / continue fading (looked at in IDLE and at
//                    the end of the low hold only)
//   level_min        lowest duty level
//   level_max        highest duty level
//   step             duty increment per ramp step (0 behaves as 1)
//   periods_per_step each ramp level lasts periods_per_step+1 PWM periods
//   hold_periods     each extreme lasts hold_periods+1 PWM periods
//   compare          registered duty value for the PWM stage
//   period_tick      registered, high in the last clock of each PWM period
//   state            current phase: IDLE=0 UP=1 HOLD_HI=2 DOWN=3 HOLD_LO=4
//   cycle_done       one-clock pulse in the tick that ends the low hold
// ---------------------------------------------------------------------------
module pwm_fade_gen #(
    parameter int CTR_LEN   = 8,
    parameter int DWELL_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CTR_LEN-1:0]   level_min,
    input  logic [CTR_LEN-1:0]   level_max,
    input  logic [CTR_LEN-1:0]   step,
    input  logic [DWELL_LEN-1:0] periods_per_step,
    input  logic [DWELL_LEN-1:0] hold_periods,
    output logic [CTR_LEN-1:0]   compare,
    output logic                 period_tick,
    output logic [2:0]           state,
    output logic                 cycle_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [CTR_LEN-1:0]   CNT_ONE   = CTR_LEN'(1);
    localparam logic [CTR_LEN-1:0]   CNT_PRE   = CTR_LEN'((1 << CTR_LEN) - 2);
    localparam logic [DWELL_LEN-1:0] DWELL_ONE = DWELL_LEN'(1);

    state_t                 state_q, state_d;
    logic [CTR_LEN-1:0]     periodCnt_q;
    logic                   tick_q;
    logic [CTR_LEN-1:0]     cmp_q, cmp_d;
    logic [DWELL_LEN-1:0]   dwell_q, dwell_d;
    logic [CTR_LEN-1:0]     minShadow_q, minShadow_d;
    logic [CTR_LEN-1:0]     maxShadow_q, maxShadow_d;
    logic [CTR_LEN-1:0]     stepShadow_q, stepShadow_d;
    logic [DWELL_LEN-1:0]   ppsShadow_q, ppsShadow_d;
    logic [DWELL_LEN-1:0]   holdShadow_q, holdShadow_d;

    logic [CTR_LEN-1:0]     stepIn;
    logic [CTR_LEN:0]       upSum;
    logic                   upHit;
    logic [CTR_LEN:0]       dnThreshold;
    logic                   dnHit;
    logic [CTR_LEN-1:0]     dnValue;
    logic [CTR_LEN:0]       restartSum;
    logic                   restartHit;

    // Free-running period counter. The tick is registered one clock ahead
    // so that it is high exactly while the counter sits at all-ones, which
    // is the last clock of the downstream PWM period.
    always_ff @(posedge clk) begin
        if (rst) begin
            periodCnt_q <= '0;
            tick_q      <= 1'b0;
        end else begin
            periodCnt_q <= periodCnt_q + CNT_ONE;
            tick_q      <= (periodCnt_q == CNT_PRE);
        end
    end

    // Phase state, duty value, dwell counter and the configuration shadow
    // copies that all ramp arithmetic works from.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmp_q        <= '0;
            dwell_q      <= '0;
            minShadow_q  <= '0;
            maxShadow_q  <= '0;
            stepShadow_q <= '0;
            ppsShadow_q  <= '0;
            holdShadow_q <= '0;
        end else begin
            state_q      <= state_d;
            cmp_q        <= cmp_d;
            dwell_q      <= dwell_d;
            minShadow_q  <= minShadow_d;
            maxShadow_q  <= maxShadow_d;
            stepShadow_q <= stepShadow_d;
            ppsShadow_q  <= ppsShadow_d;
            holdShadow_q <= holdShadow_d;
        end
    end

    // Ramp arithmetic is one bit wider than compare so that neither the sum
    // nor the down threshold can wrap; an inverted min/max simply clamps.
    // The shadow step already has the zero-means-one rule folded in.
    always_comb begin
        stepIn      = (step == '0) ? CNT_ONE : step;
        upSum       = {1'b0, cmp_q} + {1'b0, stepShadow_q};
        upHit       = (upSum >= {1'b0, maxShadow_q});
        dnThreshold = {1'b0, minShadow_q} + {1'b0, stepShadow_q};
        dnHit       = ({1'b0, cmp_q} <= dnThreshold);
        dnValue     = cmp_q - stepShadow_q;
        restartSum  = {1'b0, level_min} + {1'b0, stepIn};
        restartHit  = (restartSum >= {1'b0, level_max});
    end

    // Next-state logic. Nothing moves except in a period_tick clock, so a
    // new compare value always starts on the first clock of a PWM period.
    // Restarting from the low hold latches fresh configuration and takes the
    // first up-step straight from the fresh inputs.
    always_comb begin
        state_d      = state_q;
        cmp_d        = cmp_q;
        dwell_d      = dwell_q;
        minShadow_d  = minShadow_q;
        maxShadow_d  = maxShadow_q;
        stepShadow_d = stepShadow_q;
        ppsShadow_d  = ppsShadow_q;
        holdShadow_d = holdShadow_q;
        cycle_done   = 1'b0;

        if (tick_q) begin
            case (state_q)
                IDLE: begin
                    cmp_d = '0;
                    if (enable) begin
                        minShadow_d  = level_min;
                        maxShadow_d  = level_max;
                        stepShadow_d = stepIn;
                        ppsShadow_d  = periods_per_step;
                        holdShadow_d = hold_periods;
                        cmp_d        = level_min;
                        dwell_d      = '0;
                        state_d      = UP;
                    end
                end

                UP: begin
                    if (dwell_q == ppsShadow_q) begin
                        dwell_d = '0;
                        if (upHit) begin
                            cmp_d   = maxShadow_q;
                            state_d = HOLD_HI;
                        end else begin
                            cmp_d = upSum[CTR_LEN-1:0];
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_ONE;
                    end
                end

                HOLD_HI: begin
                    if (dwell_q == holdShadow_q) begin
                        dwell_d = '0;
                        if (dnHit) begin
                            cmp_d   = minShadow_q;
                            state_d = HOLD_LO;
                        end else begin
                            cmp_d   = dnValue;
                            state_d = DOWN;
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_ONE;
                    end
                end

                DOWN: begin
                    if (dwell_q == ppsShadow_q) begin
                        dwell_d = '0;
                        if (dnHit) begin
                            cmp_d   = minShadow_q;
                            state_d = HOLD_LO;
                        end else begin
                            cmp_d = dnValue;
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_ONE;
                    end
                end

                HOLD_LO: begin
                    if (dwell_q == holdShadow_q) begin
                        cycle_done = 1'b1;
                        dwell_d    = '0;
                        if (enable) begin
                            minShadow_d  = level_min;
                            maxShadow_d  = level_max;
                            stepShadow_d = stepIn;
                            ppsShadow_d  = periods_per_step;
                            holdShadow_d = hold_periods;
                            if (restartHit) begin
                                cmp_d   = level_max;
                                state_d = HOLD_HI;
                            end else begin
                                cmp_d   = restartSum[CTR_LEN-1:0];
                                state_d = UP;
                            end
                        end else begin
                            cmp_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_ONE;
                    end
                end

                default: begin
                    cmp_d   = '0;
                    dwell_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign compare     = cmp_q;
    assign period_tick = tick_q;
    assign state       = state_q;

endmodule
